// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants.
// Fetch FSM state encoding, the NOP word and instruction size.
package mips_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    HOLD = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  localparam logic [31:0] MIPS_NOP    = 32'h0000_0000;
  localparam int          INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: write-enable, flush (clr) to NOP, async reset.
// Ports: clk, rst_n, we, clr, d_* in, q_* out (instr, pc4, valid).
module if_id_reg
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              clr,
  input  logic [DATA_W-1:0] d_instr,
  input  logic [ADDR_W-1:0] d_pc4,
  input  logic              d_valid,
  output logic [DATA_W-1:0] q_instr,
  output logic [ADDR_W-1:0] q_pc4,
  output logic              q_valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_instr <= DATA_W'(MIPS_NOP);
      q_pc4   <= '0;
      q_valid <= 1'b0;
    end else if (clr) begin
      q_instr <= DATA_W'(MIPS_NOP);
      q_pc4   <= '0;
      q_valid <= 1'b0;
    end else if (we) begin
      q_instr <= d_instr;
      q_pc4   <= d_pc4;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, imem fetch handshake with skid, IF/ID register.
// Ports: hazard controls, EX redirects, imem req/addr/ready/rdata,
// IF/ID outputs; FETCH_PERF_EN adds perf_fetch_cnt / perf_wait_cnt.
module fetch_stage
  import mips_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PC_Write_En,
  input  logic              IF_ID_Write,
  input  logic              IF_ID_Flush,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc4,
  output logic              if_id_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_wait_cnt
`endif
);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [ADDR_W-1:0] req_addr, req_addr_nxt;
  logic [ADDR_W-1:0] pc_inc, tgt;
  logic [ADDR_W-1:0] skid_pc4;
  logic [DATA_W-1:0] skid_instr;
  logic              redirect, load_ok;
  logic              in_req, in_hold, in_drop;
  logic              load, bubble, skid_we;

  assign in_req  = (state == REQ);
  assign in_hold = (state == HOLD);
  assign in_drop = (state == DROP);

  assign redirect = branch_taken | jump;
  assign tgt = branch_taken ?
               {branch_target[ADDR_W-1:2], 2'b00} :
               {jump_target[ADDR_W-1:2], 2'b00};
  assign pc_inc = pc + ADDR_W'(INSTR_BYTES);

  // Flush blocks a load so a same-cycle response is parked, not lost.
  assign load_ok = PC_Write_En & IF_ID_Write & ~IF_ID_Flush;

  assign load = ~redirect & load_ok &
                ((in_req & imem_ready) | in_hold);

  // No instruction delivered this cycle: feed ID a bubble.
  assign bubble = IF_ID_Write &
                  (redirect | in_drop | (in_req & ~imem_ready));

  assign skid_we = in_req & imem_ready & ~redirect & ~load_ok;

  // req_addr stays on the bus while pc may already hold a redirect.
  assign imem_req  = rst_n & ~in_hold;
  assign imem_addr = req_addr;

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    req_addr_nxt = req_addr;
    unique case (state)
      REQ: begin
        if (redirect) begin
          pc_nxt = tgt;
          if (imem_ready) req_addr_nxt = tgt;
          else            state_nxt    = DROP;
        end else if (imem_ready) begin
          if (load_ok) begin
            pc_nxt       = pc_inc;
            req_addr_nxt = pc_inc;
          end else begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_nxt       = tgt;
          req_addr_nxt = tgt;
          state_nxt    = REQ;
        end else if (load_ok) begin
          pc_nxt       = pc_inc;
          req_addr_nxt = pc_inc;
          state_nxt    = REQ;
        end
      end
      DROP: begin
        if (redirect) pc_nxt = tgt;
        if (imem_ready) begin
          state_nxt    = REQ;
          req_addr_nxt = redirect ? tgt : pc;
        end
      end
      default: state_nxt = REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= REQ;
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      skid_instr <= '0;
      skid_pc4   <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      req_addr <= req_addr_nxt;
      if (skid_we) begin
        skid_instr <= imem_rdata;
        skid_pc4   <= pc_inc;
      end
    end
  end

  if_id_reg #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_if_id (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (load),
    .clr    (IF_ID_Flush | bubble),
    .d_instr(in_hold ? skid_instr : imem_rdata),
    .d_pc4  (in_hold ? skid_pc4 : pc_inc),
    .d_valid(1'b1),
    .q_instr(if_id_instr),
    .q_pc4  (if_id_pc4),
    .q_valid(if_id_valid)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_wait_cnt  <= '0;
    end else begin
      if (load && perf_fetch_cnt != '1)
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (imem_req && !imem_ready && perf_wait_cnt != '1)
        perf_wait_cnt <= perf_wait_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table,
// reset-in-DROP sequence, and random traffic against a queue model.
module tb_fetch_stage;

  logic        clk, rst_n;
  logic        pwe, ifw, fl, br, jp, rdy;
  logic [31:0] bt, jt;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] if_id_instr, if_id_pc4;
  logic        if_id_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_wait_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;

  function automatic logic [31:0] w(logic [31:0] a);
    return a ^ 32'hC0DE_0003;
  endfunction

  assign imem_rdata = w(imem_addr);

  fetch_stage #(
    .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .PC_Write_En(pwe), .IF_ID_Write(ifw), .IF_ID_Flush(fl),
    .branch_taken(br), .branch_target(bt),
    .jump(jp), .jump_target(jt),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(rdy), .imem_rdata(imem_rdata),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_wait_cnt(perf_wait_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail < 30)
        $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          rst;
    bit          pwe, ifw, fl, br, jp, rdy;
    logic [31:0] bt, jt;
    bit          e_req, e_valid;
    logic [31:0] e_addr, e_pc4, e_instr;
  } vec_t;

  vec_t tbl[$];
  vec_t nv;

  function automatic void clr_nv();
    nv = '{default: 0};
    nv.pwe = 1;
    nv.ifw = 1;
  endfunction

  function automatic void add(bit r, bit ereq, logic [31:0] ea,
                              bit ev, logic [31:0] ep);
    nv.rdy     = r;
    nv.e_req   = ereq;
    nv.e_addr  = ea;
    nv.e_valid = ev;
    nv.e_pc4   = ep;
    nv.e_instr = ev ? w(ep - 32'd4) : 32'h0;
    tbl.push_back(nv);
    clr_nv();
  endfunction

  task automatic idle();
    pwe = 1; ifw = 1; fl = 0; br = 0; jp = 0;
    bt = 0; jt = 0; rdy = 1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  // Reference model: what the spec says reaches the bus and ID.
  logic [31:0] m_pc, m_addr, m_instr, m_pc4;
  bit          m_stale, m_valid;
  logic [63:0] m_held[$];
  int unsigned m_fetch, m_wait;

  task automatic model_reset();
    m_pc = 0; m_addr = 0; m_instr = 0; m_pc4 = 0;
    m_stale = 0; m_valid = 0; m_held.delete();
    m_fetch = 0; m_wait = 0;
  endtask

  task automatic model_check(int cyc);
    bit req;
    req = (m_held.size() == 0);
    chk($sformatf("rnd%0d req", cyc), 32'(imem_req), 32'(req));
    if (req)
      chk($sformatf("rnd%0d addr", cyc), imem_addr, m_addr);
    chk($sformatf("rnd%0d valid", cyc), 32'(if_id_valid), 32'(m_valid));
    chk($sformatf("rnd%0d pc4", cyc), if_id_pc4, m_pc4);
    chk($sformatf("rnd%0d instr", cyc), if_id_instr, m_instr);
`ifdef FETCH_PERF_EN
    chk($sformatf("rnd%0d pfetch", cyc), perf_fetch_cnt, m_fetch);
    chk($sformatf("rnd%0d pwait", cyc), perf_wait_cnt, m_wait);
`endif
  endtask

  task automatic model_step();
    bit req, got, go, loaded, bub;
    logic [31:0] tgt;
    req = (m_held.size() == 0);
    got = req && rdy;
    go = pwe && ifw && !fl;
    loaded = 0;
    bub = 0;
    tgt = (br ? bt : jt) & ~32'h3;
    if (req && !rdy) m_wait++;
    if (br || jp) begin
      if (!req || got) begin
        m_held.delete();
        m_addr = tgt;
        m_stale = 0;
      end else begin
        m_stale = 1;
      end
      m_pc = tgt;
      bub = ifw;
    end else if (!req) begin
      if (go) begin
        {m_instr, m_pc4} = m_held.pop_front();
        m_valid = 1; loaded = 1;
        m_pc = m_pc + 4; m_addr = m_pc;
      end
    end else if (m_stale) begin
      if (got) begin
        m_stale = 0;
        m_addr = m_pc;
      end
      bub = ifw;
    end else if (got) begin
      if (go) begin
        m_instr = w(m_addr); m_pc4 = m_addr + 4;
        m_valid = 1; loaded = 1;
        m_pc = m_pc + 4; m_addr = m_pc;
      end else begin
        m_held.push_back({w(m_addr), m_addr + 32'd4});
      end
    end else begin
      bub = ifw;
    end
    if (!loaded && (fl || bub)) begin
      m_instr = 0; m_pc4 = 0; m_valid = 0;
    end
    if (loaded) m_fetch++;
  endtask

  initial begin
    rst_n = 0;
    idle();
    clr_nv();

    // zero wait, then 3-cycle stall as response for 0x10 arrives
    nv.rst = 1; add(1, 1, 32'h0, 0, 32'h0);
    add(1, 1, 32'h4, 1, 32'h4);
    add(1, 1, 32'h8, 1, 32'h8);
    add(1, 1, 32'hC, 1, 32'hC);
    nv.pwe = 0; nv.ifw = 0; add(1, 1, 32'h10, 1, 32'h10);
    nv.pwe = 0; nv.ifw = 0; add(1, 0, 32'h10, 1, 32'h10);
    nv.pwe = 0; nv.ifw = 0; add(1, 0, 32'h10, 1, 32'h10);
    add(1, 0, 32'h10, 1, 32'h10);
    add(1, 1, 32'h14, 1, 32'h14);
    add(1, 1, 32'h18, 1, 32'h18);
    // two wait states at 0x8
    nv.rst = 1; add(1, 1, 32'h0, 0, 32'h0);
    add(1, 1, 32'h4, 1, 32'h4);
    add(0, 1, 32'h8, 1, 32'h8);
    add(0, 1, 32'h8, 0, 32'h0);
    add(1, 1, 32'h8, 0, 32'h0);
    add(1, 1, 32'hC, 1, 32'hC);
    add(1, 1, 32'h10, 1, 32'h10);
    // branch to 0x40 while 0x20 is outstanding
    nv.rst = 1; add(1, 1, 32'h0, 0, 32'h0);
    for (int k = 1; k < 8; k++)
      add(1, 1, 32'(4 * k), 1, 32'(4 * k));
    nv.fl = 1; nv.br = 1; nv.bt = 32'h40;
    add(0, 1, 32'h20, 1, 32'h20);
    add(0, 1, 32'h20, 0, 32'h0);
    add(1, 1, 32'h20, 0, 32'h0);
    add(1, 1, 32'h40, 0, 32'h0);
    add(1, 1, 32'h44, 1, 32'h44);
    // branch beats jump; unaligned target forced to word
    nv.rst = 1; nv.br = 1; nv.bt = 32'h80;
    nv.jp = 1; nv.jt = 32'h100;
    add(1, 1, 32'h0, 0, 32'h0);
    add(1, 1, 32'h80, 0, 32'h0);
    nv.br = 1; nv.bt = 32'h83;
    add(1, 1, 32'h84, 1, 32'h84);
    add(1, 1, 32'h80, 0, 32'h0);
    add(1, 1, 32'h84, 1, 32'h84);
    // pc wrap at top of address space
    nv.rst = 1; nv.jp = 1; nv.jt = 32'hFFFF_FFFC;
    add(1, 1, 32'h0, 0, 32'h0);
    add(1, 1, 32'hFFFF_FFFC, 0, 32'h0);
    add(1, 1, 32'h0, 1, 32'h0);

    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      pwe = tbl[i].pwe; ifw = tbl[i].ifw; fl = tbl[i].fl;
      br = tbl[i].br; bt = tbl[i].bt;
      jp = tbl[i].jp; jt = tbl[i].jt; rdy = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("row%0d req", i), 32'(imem_req), 32'(tbl[i].e_req));
      if (tbl[i].e_req)
        chk($sformatf("row%0d addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("row%0d valid", i), 32'(if_id_valid),
          32'(tbl[i].e_valid));
      chk($sformatf("row%0d pc4", i), if_id_pc4, tbl[i].e_pc4);
      chk($sformatf("row%0d instr", i), if_id_instr, tbl[i].e_instr);
      @(posedge clk);
      #1;
    end

    // reset asserted while a stale request drains
    do_reset();
    rdy = 0; br = 1; bt = 32'h40;
    @(negedge clk);
    chk("drop0 addr", imem_addr, 32'h0);
    @(posedge clk);
    #1 br = 0;
    @(negedge clk);
    chk("drop1 req", 32'(imem_req), 32'd1);
    chk("drop1 addr", imem_addr, 32'h0);
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("rst req", 32'(imem_req), 32'd0);
    chk("rst valid", 32'(if_id_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    idle();
    @(negedge clk);
    chk("rel req", 32'(imem_req), 32'd1);
    chk("rel addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_EN
    chk("rel pfetch", perf_fetch_cnt, 32'd0);
    chk("rel pwait", perf_wait_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rel2 addr", imem_addr, 32'h4);
    chk("rel2 pc4", if_id_pc4, 32'h4);
    chk("rel2 valid", 32'(if_id_valid), 32'd1);
    @(posedge clk);
    #1;

    // random traffic against the model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom_range(99) < 70);
      pwe = ($urandom_range(99) < 85);
      ifw = ($urandom_range(99) < 85);
      fl  = ($urandom_range(99) < 8);
      br  = ($urandom_range(99) < 6);
      jp  = ($urandom_range(99) < 4);
      bt  = $urandom();
      jt  = $urandom();
      @(negedge clk);
      model_check(c);
      model_step();
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
